// File: rtl/jt51_pkg.sv
// Shared constants and types for the jt51 accumulator slot sequencer.
package jt51_pkg;

   localparam int unsigned SLOTS    = 32;
   localparam int unsigned CHANNELS = 8;
   localparam int unsigned SLOT_W   = 5;
   localparam int unsigned CH_W     = 3;
   localparam int unsigned CON_W    = 3;
   localparam int unsigned RL_W     = 2;
   localparam int unsigned STB_SLOT = 15;

   typedef enum logic [1:0] {
      GRP_M1 = 2'd0,
      GRP_M2 = 2'd1,
      GRP_C1 = 2'd2,
      GRP_C2 = 2'd3
   } grp_e;

   typedef struct packed {
      logic [CON_W-1:0] con;
      logic [RL_W-1:0]  rl;
   } ch_cfg_t;

   localparam ch_cfg_t CFG_RST = '{con: '0, rl: 2'b11};

endpackage

// File: rtl/jt51_acc_cfg.sv
// Double-buffered per-channel config: writes land in a pending bank and move
// to the active bank only at the frame boundary (apply).
module jt51_acc_cfg
   import jt51_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [CON_W-1:0]    cfg_con,
   input  logic [RL_W-1:0]     cfg_rl,
   input  logic                apply,
   input  logic [CH_W-1:0]     rd_ch,
   output logic [CON_W-1:0]    con_I,
   output logic [RL_W-1:0]     rl_I,
   output logic [CHANNELS-1:0] pend
);

   ch_cfg_t                active  [CHANNELS];
   ch_cfg_t                pending [CHANNELS];
   ch_cfg_t                wr_cfg;
   logic [CHANNELS-1:0]    wr_sel;

   always_comb begin
      wr_sel = '0;
      if (cfg_we) wr_sel[cfg_ch] = 1'b1;
   end

   assign wr_cfg = '{con: cfg_con, rl: cfg_rl};

   // A write on the apply edge bypasses pending straight into active
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            active[i]  <= CFG_RST;
            pending[i] <= CFG_RST;
         end
         pend <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_sel[i]) pending[i] <= wr_cfg;
            if (apply && (wr_sel[i] || pend[i])) begin
               active[i] <= wr_sel[i] ? wr_cfg : pending[i];
               pend[i]   <= 1'b0;
            end else if (wr_sel[i]) begin
               pend[i] <= 1'b1;
            end
         end
      end
   end

   assign con_I = active[rd_ch].con;
   assign rl_I  = active[rd_ch].rl;

endmodule

// File: rtl/jt51_acc_seq.sv
// Accumulator slot sequencer: slot counter, delayed accumulator slot decode,
// sample strobe and frame-synchronous config/noise-enable update.
module jt51_acc_seq
   import jt51_pkg::*;
#(
   parameter int unsigned DLY = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk_en,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [CON_W-1:0]    cfg_con,
   input  logic [RL_W-1:0]     cfg_rl,
   input  logic                ne_we,
   input  logic                ne_in,
   output logic                m1_enters,
   output logic                m2_enters,
   output logic                c1_enters,
   output logic                c2_enters,
   output logic                op31_acc,
   output logic [CON_W-1:0]    con_I,
   output logic [RL_W-1:0]     rl_I,
   output logic                ne,
   output logic                sample_stb,
   output logic [SLOT_W-1:0]   slot,
   output logic [CHANNELS-1:0] pend
);

   logic [SLOT_W-1:0] aslot;
   grp_e              grp;
   logic              apply;
   logic              ne_pend;

   always_ff @(posedge clk) begin
      if (rst)         slot <= '0;
      else if (clk_en) slot <= slot + SLOT_W'(1);
   end

   // Modulo-32 subtraction gives the delayed slot directly
   assign aslot = slot - SLOT_W'(DLY);
   assign grp   = grp_e'(aslot[4:3]);
   assign apply = clk_en && (aslot == SLOT_W'(SLOTS - 1));

   assign m1_enters  = (grp == GRP_M1);
   assign m2_enters  = (grp == GRP_M2);
   assign c1_enters  = (grp == GRP_C1);
   assign c2_enters  = (grp == GRP_C2);
   assign op31_acc   = (aslot == SLOT_W'(SLOTS - 1));
   assign sample_stb = !rst && clk_en && (aslot == SLOT_W'(STB_SLOT));

   always_ff @(posedge clk) begin
      if (rst) begin
         ne_pend <= 1'b0;
         ne      <= 1'b0;
      end else begin
         if (ne_we) ne_pend <= ne_in;
         if (apply) ne      <= ne_pend;
      end
   end

   jt51_acc_cfg u_cfg (
      .clk     (clk),
      .rst     (rst),
      .cfg_we  (cfg_we),
      .cfg_ch  (cfg_ch),
      .cfg_con (cfg_con),
      .cfg_rl  (cfg_rl),
      .apply   (apply),
      .rd_ch   (aslot[2:0]),
      .con_I   (con_I),
      .rl_I    (rl_I),
      .pend    (pend)
   );

endmodule
